// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the branch sequencer and its ALU.
// - Opcode constants (shared with the 4-bit ALU)
// - Sequencer state encoding
// - Instruction field bit positions
// - Helper to classify register-writing ALU opcodes
package branch_sequencer_pkg;

    localparam int unsigned InstrW = 12;

    // Opcodes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Instruction fields: [11:9] op, [8:7] ra, [6:5] rb, [4:0] off5
    localparam int unsigned OpHi  = 11;
    localparam int unsigned OpLo  = 9;
    localparam int unsigned RaHi  = 8;
    localparam int unsigned RaLo  = 7;
    localparam int unsigned RbHi  = 6;
    localparam int unsigned RbLo  = 5;
    localparam int unsigned OffHi = 4;
    localparam int unsigned OffLo = 0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } seq_state_e;

    // ADD/SUB/AND/OR/SLT write reg[ra]; branches and HALT do not.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op <= OP_SLT);
    endfunction

endpackage

// File: rtl/branch_regfile.sv
// 4 x 4-bit register file for the branch sequencer.
// Ports:
//   clk, rst_n          clock, asynchronous active-low clear of all registers
//   raddr_a_i/rdata_a_o combinational read port A
//   raddr_b_i/rdata_b_o combinational read port B
//   we_i/waddr_i/wdata_i single synchronous write port
module branch_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raddr_a_i,
    output logic [3:0] rdata_a_o,
    input  logic [1:0] raddr_b_i,
    output logic [3:0] rdata_b_o,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [3:0] wdata_i
);

    logic [3:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/branch_sequencer.sv
// Multicycle control stage ahead of a 4-bit branch-capable ALU.
// Sequence per instruction: FETCH (req/ack) -> DECODE -> EXEC -> WB.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   run_en                 allows leaving IDLE / continuing after WB
//   imem_req/addr/rdata/ack instruction fetch handshake (addr == pc)
//   alu_a/alu_b/alu_op     registered ALU operands and opcode
//   alu_result/alu_zero    combinational ALU response
//   pre_we/addr/wdata      register preload, honoured in IDLE only
//   pc, instr_done, retire_cnt, halted  status
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_en,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [11:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_op,
    input  logic [3:0]        alu_result,
    input  logic              alu_zero,
    input  logic              pre_we,
    input  logic [1:0]        pre_addr,
    input  logic [3:0]        pre_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              instr_done,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              halted
);

    seq_state_e       state_q;
    logic [11:0]      instr_q;
    logic [3:0]       res_q;
    logic             zero_q;
    logic [PC_W-1:0]  pc_q;
    logic [3:0]       alu_a_q, alu_b_q;
    logic [2:0]       alu_op_q;
    logic             imem_req_q;
    logic             instr_done_q;
    logic [CNT_W-1:0] retire_cnt_q;
    logic             halted_q;

    logic [2:0]       op;
    logic [1:0]       ra, rb;
    logic [4:0]       off5;
    logic [PC_W-1:0]  off_ext;
    logic [3:0]       rf_rdata_a, rf_rdata_b;
    logic             rf_we;
    logic [1:0]       rf_waddr;
    logic [3:0]       rf_wdata;

    assign op      = instr_q[OpHi:OpLo];
    assign ra      = instr_q[RaHi:RaLo];
    assign rb      = instr_q[RbHi:RbLo];
    assign off5    = instr_q[OffHi:OffLo];
    assign off_ext = {{(PC_W-5){off5[4]}}, off5};

    // Preload (IDLE) and writeback (WB) share the single write port.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = pre_addr;
        rf_wdata = pre_wdata;
        if (state_q == StIdle) begin
            rf_we = pre_we;
        end else if (state_q == StWb && is_alu_op(op)) begin
            rf_we    = 1'b1;
            rf_waddr = ra;
            rf_wdata = res_q;
        end
    end

    branch_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (ra),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (rb),
        .rdata_b_o (rf_rdata_b),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            instr_q      <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            pc_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            imem_req_q   <= 1'b0;
            instr_done_q <= 1'b0;
            retire_cnt_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            instr_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (run_en) begin
                        state_q    <= StFetch;
                        imem_req_q <= 1'b1;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        instr_q    <= imem_rdata;
                        if (imem_rdata[OpHi:OpLo] == OP_HALT) begin
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= StDecode;
                        end
                    end
                end
                StDecode: begin
                    alu_a_q  <= rf_rdata_a;
                    alu_b_q  <= rf_rdata_b;
                    alu_op_q <= op;
                    state_q  <= StExec;
                end
                StExec: begin
                    res_q        <= alu_result;
                    zero_q       <= alu_zero;
                    instr_done_q <= 1'b1;  // high for the whole WB cycle
                    state_q      <= StWb;
                end
                StWb: begin
                    // ALU flag decides both BEQ and BNE; the ALU inverts the compare for BNE.
                    if ((op == OP_BEQ || op == OP_BNE) && zero_q) begin
                        pc_q <= pc_q + off_ext;
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                    retire_cnt_q <= retire_cnt_q + CNT_W'(1);
                    if (run_en) begin
                        state_q    <= StFetch;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign pc         = pc_q;
    assign instr_done = instr_done_q;
    assign retire_cnt = retire_cnt_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: behavioural ALU and instruction source,
// a table of back-to-back instructions, then hand sequences for reset during
// fetch, PC wrap, stalled ack with ignored preload, and HALT.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [11:0] imem_rdata;
    logic        imem_ack;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_result;
    logic        alu_zero;
    logic        pre_we = 1'b0;
    logic [1:0]  pre_addr = 2'd0;
    logic [3:0]  pre_wdata = 4'd0;
    logic [7:0]  pc;
    logic        instr_done;
    logic [7:0]  retire_cnt;
    logic        halted;

    logic        ack_en = 1'b0;
    logic [11:0] cur_instr = 12'h000;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: BEQ flags equal operands, BNE flags unequal operands.
    always_comb begin
        alu_result = 4'd0;
        alu_zero   = 1'b0;
        case (alu_op)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = {3'b000, (alu_a < alu_b)};
            3'd5: alu_result = alu_a - alu_b;
            3'd6: alu_result = alu_a - alu_b;
            default: alu_result = 4'd0;
        endcase
        if (alu_op == 3'd5)      alu_zero = (alu_a == alu_b);
        else if (alu_op == 3'd6) alu_zero = (alu_a != alu_b);
        else                     alu_zero = (alu_result == 4'd0);
    end

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = cur_instr;

    branch_sequencer #(
        .PC_W  (8),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_en     (run_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .pre_we     (pre_we),
        .pre_addr   (pre_addr),
        .pre_wdata  (pre_wdata),
        .pc         (pc),
        .instr_done (instr_done),
        .retire_cnt (retire_cnt),
        .halted     (halted)
    );

    typedef struct {
        logic [11:0] instr;
        logic [7:0]  pc;
        logic [15:0] regs;   // {r3, r2, r1, r0}
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] regs_now();
        return {dut.u_regfile.regs_q[3], dut.u_regfile.regs_q[2],
                dut.u_regfile.regs_q[1], dut.u_regfile.regs_q[0]};
    endfunction

    task automatic preload(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        pre_we    = 1'b1;
        pre_addr  = a;
        pre_wdata = d;
        @(negedge clk);
        pre_we    = 1'b0;
    endtask

    // Entered just after the edge that moved the DUT into FETCH with ack enabled.
    task automatic run_one(input string tag, input logic [11:0] instr,
                           input logic [7:0] fetch_pc, input logic [11:0] next_instr,
                           input bit stop, input logic [7:0] exp_pc,
                           input logic [15:0] exp_regs, input logic [7:0] exp_cnt);
        int cyc = 0;
        bit seen = 1'b0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({tag, " req"}, imem_req, 1'b1);
                check({tag, " addr"}, imem_addr, fetch_pc);
            end
            if (cyc == 3) check({tag, " alu_op"}, alu_op, instr[11:9]);
            if (instr_done) begin
                seen = 1'b1;
                cur_instr = next_instr;
                if (stop) run_en = 1'b0;
            end else if (cyc > 1) begin
                check({tag, " req_quiet"}, imem_req, 1'b0);
            end
        end
        check({tag, " latency"}, cyc, 4);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, instr_done, 1'b0);
        check({tag, " pc"}, pc, exp_pc);
        check({tag, " regs"}, regs_now(), exp_regs);
        check({tag, " retire_cnt"}, retire_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{12'h0C0, 8'd1, 16'h7587, 8'd1};   // ADD r1,r2
        vecs[1] = '{12'h320, 8'd2, 16'h7D87, 8'd2};   // SUB r2,r1
        vecs[2] = '{12'h500, 8'd3, 16'h7587, 8'd3};   // AND r2,r0
        vecs[3] = '{12'h920, 8'd4, 16'h7187, 8'd4};   // SLT r2,r1
        vecs[4] = '{12'h720, 8'd5, 16'h7987, 8'd5};   // OR  r2,r1
        vecs[5] = '{12'hA7E, 8'd3, 16'h7987, 8'd6};   // BEQ r0,r3,-2 taken
        vecs[6] = '{12'hC63, 8'd4, 16'h7987, 8'd7};   // BNE r0,r3,+3 not taken
        vecs[7] = '{12'hC23, 8'd7, 16'h7987, 8'd8};   // BNE r0,r1,+3 taken
        vecs[8] = '{12'hA3C, 8'd8, 16'h7987, 8'd9};   // BEQ r0,r1,-4 not taken
        vecs[9] = '{12'h200, 8'd9, 16'h7980, 8'd10};  // SUB r0,r0

        // Reset values
        repeat (2) @(negedge clk);
        check("rst req", imem_req, 1'b0);
        check("rst pc", pc, 8'd0);
        check("rst regs", regs_now(), 16'h0000);
        check("rst cnt", retire_cnt, 8'd0);
        check("rst halted", halted, 1'b0);
        check("rst done", instr_done, 1'b0);
        check("rst alu", {alu_a, alu_b, 1'b0, alu_op}, 12'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle req", imem_req, 1'b0);

        preload(2'd0, 4'd7);
        preload(2'd1, 4'd3);
        preload(2'd2, 4'd5);
        preload(2'd3, 4'd7);
        check("preload regs", regs_now(), 16'h7537);

        // Back-to-back table run
        cur_instr = vecs[0].instr;
        ack_en    = 1'b1;
        @(negedge clk);
        run_en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].instr,
                    (i == 0) ? 8'd0 : vecs[i-1].pc,
                    (i < 9) ? vecs[i+1].instr : 12'h000,
                    (i == 9), vecs[i].pc, vecs[i].regs, vecs[i].cnt);
        end
        @(negedge clk);
        check("back idle req", imem_req, 1'b0);

        // Reset asserted in the middle of a stalled fetch
        ack_en = 1'b0;
        @(negedge clk);
        run_en = 1'b1;
        @(posedge clk);
        #1;
        check("midfetch req", imem_req, 1'b1);
        run_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midfetch rst req", imem_req, 1'b0);
        check("midfetch rst pc", pc, 8'd0);
        check("midfetch rst regs", regs_now(), 16'h0000);
        check("midfetch rst cnt", retire_cnt, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Branch wrap below zero, then SUB wrapping the 4-bit result
        preload(2'd0, 4'd2);
        preload(2'd1, 4'd3);
        cur_instr = 12'hA1F;                 // BEQ r0,r0,-1
        ack_en    = 1'b1;
        @(negedge clk);
        run_en = 1'b1;
        @(posedge clk);
        #1;
        run_one("wrap_beq", 12'hA1F, 8'h00, 12'h220, 1'b0, 8'hFF, 16'h0032, 8'd1);
        run_one("wrap_sub", 12'h220, 8'hFF, 12'h020, 1'b1, 8'h00, 16'h003F, 8'd2);
        @(negedge clk);
        check("wrap idle req", imem_req, 1'b0);

        // Ack held low for 5 cycles while preload is attempted
        ack_en = 1'b0;
        @(negedge clk);
        run_en = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d req", k), imem_req, 1'b1);
            check($sformatf("stall%0d addr", k), imem_addr, 8'h00);
            pre_we    = ~pre_we;
            pre_addr  = 2'd0;
            pre_wdata = 4'd5;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        check("stall regs", regs_now(), 16'h003F);
        ack_en = 1'b1;
        run_one("stall_add", 12'h020, 8'h00, 12'hE00, 1'b0, 8'h01, 16'h0032, 8'd3);

        // HALT
        @(posedge clk);
        #1;
        check("halt halted", halted, 1'b1);
        check("halt req", imem_req, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("halt%0d", k), {halted, imem_req, instr_done}, 3'b100);
        end
        check("halt cnt", retire_cnt, 8'd3);
        check("halt pc", pc, 8'h01);
        rst_n = 1'b0;
        #1;
        check("halt rst", halted, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        run_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
